// File: rtl/serdes_pkg.sv
// Shared types for the serializer link arbiter.
package serdes_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first eligible channel scanning upward from last_winner+1, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         eligible,
  input  logic [$clog2(NUM_CH)-1:0] last_winner,
  output logic [$clog2(NUM_CH)-1:0] winner,
  output logic                      found
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned DBL_W = 2 * NUM_CH;

  logic [DBL_W-1:0] dbl;
  logic [DBL_W-1:0] window;
  logic [DBL_W-1:0] masked;
  int unsigned      lw;
  int unsigned      idx;

  // Window covers positions last_winner+1 .. last_winner+NUM_CH of the doubled mask
  always_comb begin
    lw     = 32'(last_winner);
    dbl    = {eligible, eligible};
    window = '0;
    for (int unsigned k = 0; k < DBL_W; k++) begin
      if ((k > lw) && (k <= lw + NUM_CH)) window[k] = 1'b1;
    end
    masked = dbl & window;
  end

  // Lowest set bit of the windowed mask, folded back into channel range
  always_comb begin
    idx   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < DBL_W; k++) begin
      if (!found && masked[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
    if (idx >= NUM_CH) idx = idx - NUM_CH;
    winner = CH_W'(idx);
  end

endmodule

// File: rtl/serdes_link_arbiter.sv
// Round-robin arbiter sharing one serializer link between NUM_CH requesters, bursts of up to BURST_LEN.
module serdes_link_arbiter
  import serdes_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            chan_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]        ser_data,
  output logic                         ser_valid,
  input  logic                         ser_ready,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  output logic                         grant_valid,
  output logic                         busy
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  arb_state_t      state;
  logic [CH_W-1:0] last_winner;
  logic [CNT_W-1:0] burst_cnt;

  logic [CH_W-1:0]       pick_winner;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_enable;
  logic                  active;
  logic                  xfer;
  logic                  burst_last;
  logic                  grant_exit;

  rr_priority_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .eligible    (req_valid & chan_enable),
    .last_winner (last_winner),
    .winner      (pick_winner),
    .found       (pick_found)
  );

  // Select the granted channel's word, valid and enable
  always_comb begin
    sel_data   = '0;
    sel_valid  = 1'b0;
    sel_enable = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_id == CH_W'(i)) begin
        sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid  = req_valid[i];
        sel_enable = chan_enable[i];
      end
    end
  end

  // Pass-through to the serializer; reset blocks any transfer in its own cycle
  always_comb begin
    active    = (state == ARB_GRANT) && !rst;
    ser_valid = active && sel_valid;
    ser_data  = active ? sel_data : '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (active && (grant_id == CH_W'(i))) req_ready[i] = ser_ready;
    end
    xfer       = ser_valid && ser_ready;
    burst_last = (burst_cnt == CNT_W'(BURST_LEN - 1));
    grant_exit = (xfer && burst_last) || !sel_valid || (!sel_enable && !xfer);
  end

  assign grant_valid = (state == ARB_GRANT);
  assign busy        = (state != ARB_IDLE);

  // Arbitration FSM with grant, round-robin pointer and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant_id    <= '0;
      burst_cnt   <= '0;
      last_winner <= CH_W'(NUM_CH - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_winner;
            last_winner <= pick_winner;
            burst_cnt   <= '0;
            state       <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer && !burst_last) burst_cnt <= burst_cnt + CNT_W'(1);
          if (grant_exit) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_link_arbiter.sv
// Randomized bench for serdes_link_arbiter against a cycle-level behavioural model.
module tb_serdes_link_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int BL     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    chan_enable;
  logic [NUM_CH*DW-1:0] req_data;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_ready;
  logic [DW-1:0]        ser_data;
  logic                 ser_valid;
  logic                 ser_ready;
  logic [1:0]           grant_id;
  logic                 grant_valid;
  logic                 busy;

  always #5 clk = ~clk;

  serdes_link_arbiter #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chan_enable (chan_enable),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .ser_ready   (ser_ready),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: granted channel (-1 = none), reported id, words this grant, last winner
  int m_g    = -1;
  int m_gid  = 0;
  int m_cnt  = 0;
  int m_last = NUM_CH - 1;
  int grants_seen[NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [NUM_CH-1:0] exp_rr;
    logic              exp_sv;
    exp_rr = '0;
    exp_sv = 1'b0;
    if (m_g >= 0 && !rst) begin
      exp_sv       = req_valid[m_g];
      exp_rr[m_g]  = ser_ready;
    end
    check("ser_valid",   32'(ser_valid),   32'(exp_sv));
    check("req_ready",   32'(req_ready),   32'(exp_rr));
    check("grant_valid", 32'(grant_valid), 32'(m_g >= 0));
    check("busy",        32'(busy),        32'(m_g >= 0));
    check("grant_id",    32'(grant_id),    32'(m_gid));
    if (exp_sv) check("ser_data", 32'(ser_data), 32'(req_data[m_g*DW +: DW]));
  endtask

  // Advance the reference by one clock edge using the inputs held across it
  task automatic model_edge();
    bit x;
    if (rst) begin
      m_g = -1; m_gid = 0; m_cnt = 0; m_last = NUM_CH - 1;
    end else if (m_g < 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (m_last + k) % NUM_CH;
        if (req_valid[c] && chan_enable[c]) begin
          m_g = c; m_gid = c; m_last = c; m_cnt = 0;
          grants_seen[c]++;
          break;
        end
      end
    end else begin
      x = req_valid[m_g] && ser_ready;
      if (x) m_cnt++;
      if ((x && m_cnt == BL) || !req_valid[m_g] || (!chan_enable[m_g] && !x)) m_g = -1;
    end
  endtask

  task automatic cycle();
    #2;
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    rst         = 1'b1;
    chan_enable = '1;
    req_valid   = '0;
    ser_ready   = 1'b1;
    req_data    = '0;
    for (int i = 0; i < NUM_CH; i++) grants_seen[i] = 0;

    @(posedge clk);
    model_edge();
    #1;
    cycle();
    rst = 1'b0;

    // All channels valid, link always ready
    for (int n = 0; n < 20; n++) begin
      req_valid = '1; chan_enable = '1; ser_ready = 1'b1; rand_data();
      cycle();
    end

    // Only ch2 requesting; other ready bits must stay low
    for (int n = 0; n < 16; n++) begin
      req_valid = 4'b0100; ser_ready = 1'b1; rand_data();
      cycle();
    end

    // ch1 with a 10-cycle serializer stall mid-burst, data held stable
    req_data = 32'hA5A5_A5A5;
    for (int n = 0; n < 24; n++) begin
      req_valid = 4'b0010;
      ser_ready = !(n >= 3 && n < 13);
      cycle();
    end

    // ch2 disabled while everyone requests
    for (int i = 0; i < NUM_CH; i++) grants_seen[i] = 0;
    for (int n = 0; n < 24; n++) begin
      req_valid = '1; chan_enable = 4'b1011; ser_ready = 1'b1; rand_data();
      cycle();
    end
    check("ch2_masked_grants", 32'(grants_seen[2]), 32'd0);

    // Reset pulsed while ch3 holds the grant
    chan_enable = '1;
    req_valid   = '1;
    begin
      int waited;
      waited = 0;
      while (!(m_g == 3 && m_cnt == 0) && waited < 40) begin
        rand_data();
        cycle();
        waited++;
      end
      check("reach_ch3_grant", 32'(m_g == 3), 32'd1);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      rand_data();
      cycle();
    end

    // Fully random traffic, enables, stalls and resets
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
        chan_enable[i] = ($urandom_range(0, 9) != 0);
      end
      ser_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      rand_data();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
